// File: rtl/vga_scan_driver_if.sv
// Scan bus between the VGA scan driver and the combinational sprite/mask lookup blocks.
// The driver presents coordinates and timing strobes; the lookup side returns a 3-bit colour.
interface vga_scan_driver_if;
  logic [9:0] px;
  logic [9:0] py;
  logic       pix_tick;
  logic       frame_start;
  logic [2:0] col_in;

  modport master (
    output px,
    output py,
    output pix_tick,
    output frame_start,
    input  col_in
  );

  modport slave (
    input  px,
    input  py,
    input  pix_tick,
    input  frame_start,
    output col_in
  );
endinterface

// File: rtl/vga_scan_driver.sv
// VGA scan generator: pixel divider, px/py scan counters, sync decode and a LAT-deep
// alignment pipeline so blanked colour and both syncs leave on the same pixel tick.
module vga_scan_driver #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LAT      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_scan_driver_if.master  scan,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic [2:0]         rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [2:0] DIV_LAST   = 3'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [2:0] div_q, div_d;
  logic       tick_q, tick_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic       fs_q, fs_d;
  logic [2:0] rgb_q, rgb_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic act_raw, hs_raw, vs_raw;
  logic act_dly, hs_dly, vs_dly;

  // Divider and scan counters; tick_q is high in the clk whose closing edge advances the scan
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
    tick_d = (div_d == DIV_LAST);
    px_d   = px_q;
    py_d   = py_q;
    fs_d   = 1'b0;
    if (tick_q) begin
      if (px_q == H_LAST) begin
        px_d = 10'd0;
        if (py_q == V_LAST) begin
          py_d = 10'd0;
          fs_d = 1'b1;
        end else begin
          py_d = py_q + 10'd1;
        end
      end else begin
        px_d = px_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 3'd0;
      tick_q <= 1'b0;
      px_q   <= 10'd0;
      py_q   <= 10'd0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      px_q   <= px_d;
      py_q   <= py_d;
      fs_q   <= fs_d;
    end
  end

  // Raw timing for the coordinate currently presented on px/py
  always_comb begin
    act_raw = (px_q < H_ACT) && (py_q < V_ACT);
    hs_raw  = !in_window(px_q, H_SYNC_BEG, H_SYNC_END);
    vs_raw  = !in_window(py_q, V_SYNC_BEG, V_SYNC_END);
  end

  generate
    if (LAT == 0) begin : g_nodly
      assign act_dly = act_raw;
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
    end else begin : g_dly
      logic [LAT-1:0] act_sh_q, act_sh_d;
      logic [LAT-1:0] hs_sh_q, hs_sh_d;
      logic [LAT-1:0] vs_sh_q, vs_sh_d;

      // Timing flags wait here for the lookup path so they meet their colour
      always_comb begin
        act_sh_d = act_sh_q;
        hs_sh_d  = hs_sh_q;
        vs_sh_d  = vs_sh_q;
        if (tick_q) begin
          act_sh_d    = act_sh_q << 1;
          act_sh_d[0] = act_raw;
          hs_sh_d     = hs_sh_q << 1;
          hs_sh_d[0]  = hs_raw;
          vs_sh_d     = vs_sh_q << 1;
          vs_sh_d[0]  = vs_raw;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_sh_q <= '0;
          hs_sh_q  <= '1;
          vs_sh_q  <= '1;
        end else begin
          act_sh_q <= act_sh_d;
          hs_sh_q  <= hs_sh_d;
          vs_sh_q  <= vs_sh_d;
        end
      end

      assign act_dly = act_sh_q[LAT-1];
      assign hs_dly  = hs_sh_q[LAT-1];
      assign vs_dly  = vs_sh_q[LAT-1];
    end
  endgenerate

  // Output stage; the mux keeps blanking-time garbage on col_in away from the pins
  always_comb begin
    rgb_d      = rgb_q;
    video_on_d = video_on_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    if (tick_q) begin
      rgb_d      = act_dly ? scan.col_in : 3'b000;
      video_on_d = act_dly;
      hsync_d    = hs_dly;
      vsync_d    = vs_dly;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q      <= 3'b000;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      rgb_q      <= rgb_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign scan.px          = px_q;
  assign scan.py          = py_q;
  assign scan.pix_tick    = tick_q;
  assign scan.frame_start = fs_q;
  assign video_on         = video_on_q;
  assign hsync            = hsync_q;
  assign vsync            = vsync_q;
  assign rgb              = rgb_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: a full-size instance for line timing, two shrunken-timing instances
// (LAT=0 and LAT=2) for frame, blanking, latency and mid-frame reset scenarios.
module tb_vga_scan_driver;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [2:0] col_def, col_sm;
  logic       vo_def, hs_def, vs_def;
  logic [2:0] rgb_def;
  logic       vo_sm, hs_sm, vs_sm;
  logic [2:0] rgb_sm;
  logic       vo_lat, hs_lat, vs_lat;
  logic [2:0] rgb_lat;
  logic [2:0] lk_d1, lk_d2;

  vga_scan_driver_if if_def ();
  vga_scan_driver_if if_sm ();
  vga_scan_driver_if if_lat ();

  assign if_def.col_in = col_def;
  assign if_sm.col_in  = col_sm;
  assign if_lat.col_in = lk_d2;

  vga_scan_driver dut_def (
    .clk(clk), .rst_n(rst_n), .scan(if_def),
    .video_on(vo_def), .hsync(hs_def), .vsync(vs_def), .rgb(rgb_def)
  );

  vga_scan_driver #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_sm (
    .clk(clk), .rst_n(rst_n), .scan(if_sm),
    .video_on(vo_sm), .hsync(hs_sm), .vsync(vs_sm), .rgb(rgb_sm)
  );

  vga_scan_driver #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .LAT(2)
  ) dut_lat (
    .clk(clk), .rst_n(rst_n), .scan(if_lat),
    .video_on(vo_lat), .hsync(hs_lat), .vsync(vs_lat), .rgb(rgb_lat)
  );

  // Two-tick lookup stand-in: colour is px[2:0] of the coordinate two ticks back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_d1 <= 3'd0;
      lk_d2 <= 3'd0;
    end else if (if_lat.pix_tick) begin
      lk_d1 <= if_lat.px[2:0];
      lk_d2 <= lk_d1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    col_def = 3'b111;
    col_sm  = 3'b111;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (if_def.px !== 10'd0) begin n_fail++; $display("FAIL reset_px: got %0d exp 0", if_def.px); end
    n_chk++; if (if_def.py !== 10'd0) begin n_fail++; $display("FAIL reset_py: got %0d exp 0", if_def.py); end
    n_chk++; if (hs_def !== 1'b1 || vs_def !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b exp 1 1", hs_def, vs_def); end
    n_chk++; if (rgb_def !== 3'b000 || vo_def !== 1'b0) begin n_fail++; $display("FAIL reset_rgb: got rgb=%b vo=%b exp 000 0", rgb_def, vo_def); end
    n_chk++; if (if_def.frame_start !== 1'b0 || if_def.pix_tick !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got fs=%b tick=%b exp 0 0", if_def.frame_start, if_def.pix_tick); end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++; if (if_def.px !== 10'd20) begin n_fail++; $display("FAIL run_px: got %0d exp 20", if_def.px); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (if_def.px !== 10'd0 || if_def.pix_tick !== 1'b0) begin n_fail++; $display("FAIL async_clear: got px=%0d tick=%b exp 0 0", if_def.px, if_def.pix_tick); end
    n_chk++; if (rgb_def !== 3'b000 || vo_def !== 1'b0 || hs_def !== 1'b1) begin n_fail++; $display("FAIL async_out: got rgb=%b vo=%b hs=%b exp 000 0 1", rgb_def, vo_def, hs_def); end
  endtask

  task automatic test_line_timing;
    int cnt, f1, f2, r1, tick_bad;
    logic hs_prev;
    col_def = 3'b101;
    do_reset();
    cnt = 0; f1 = -1; f2 = -1; r1 = -1; tick_bad = 0; hs_prev = 1'b1;
    while (cnt < 3400 && f2 < 0) begin
      @(negedge clk);
      cnt++;
      if (if_def.pix_tick !== cnt[0]) tick_bad++;
      if (hs_prev && !hs_def) begin
        if (f1 < 0) f1 = cnt; else f2 = cnt;
      end
      if (!hs_prev && hs_def && r1 < 0) r1 = cnt;
      hs_prev = hs_def;
      if (cnt == 2) begin
        n_chk++; if (rgb_def !== 3'b101 || vo_def !== 1'b1) begin n_fail++; $display("FAIL first_pixel: got rgb=%b vo=%b exp 101 1", rgb_def, vo_def); end
      end
      if (cnt == 1280) begin
        n_chk++; if (vo_def !== 1'b1) begin n_fail++; $display("FAIL last_active: got vo=%b exp 1", vo_def); end
      end
      if (cnt == 1282) begin
        n_chk++; if (vo_def !== 1'b0 || rgb_def !== 3'b000) begin n_fail++; $display("FAIL first_blank: got vo=%b rgb=%b exp 0 000", vo_def, rgb_def); end
      end
      if (cnt == 1314) begin
        n_chk++; if (if_def.px !== 10'd657) begin n_fail++; $display("FAIL px_at_hs: got %0d exp 657", if_def.px); end
      end
    end
    n_chk++; if (tick_bad != 0) begin n_fail++; $display("FAIL tick_period: got %0d bad clks exp 0", tick_bad); end
    n_chk++; if (f1 != 1314) begin n_fail++; $display("FAIL hs_fall: got %0d exp 1314", f1); end
    n_chk++; if (r1 - f1 != 192) begin n_fail++; $display("FAIL hs_width: got %0d exp 192", r1 - f1); end
    n_chk++; if (f2 - f1 != 1600) begin n_fail++; $display("FAIL line_period: got %0d exp 1600", f2 - f1); end
  endtask

  task automatic test_frame_timing;
    int cnt, nfs, fs1, fs2, vf1, vr1, act_clks, bad, pymax;
    logic vs_prev;
    col_sm = 3'b101;
    do_reset();
    nfs = 0; fs1 = -1; fs2 = -1; vf1 = -1; vr1 = -1; act_clks = 0; bad = 0; pymax = 0; vs_prev = 1'b1;
    for (cnt = 1; cnt <= 1600; cnt++) begin
      @(negedge clk);
      if (if_sm.frame_start === 1'b1) begin
        nfs++;
        if (nfs == 1) fs1 = cnt; else if (nfs == 2) fs2 = cnt;
      end
      if (int'(if_sm.py) > pymax) pymax = int'(if_sm.py);
      if (vs_prev && !vs_sm && vf1 < 0) vf1 = cnt;
      if (!vs_prev && vs_sm && vr1 < 0) vr1 = cnt;
      vs_prev = vs_sm;
      if (rgb_sm !== (vo_sm ? 3'b101 : 3'b000)) bad++;
      if (cnt <= 750 && vo_sm === 1'b1) act_clks++;
      if (cnt == 750) begin
        n_chk++; if (if_sm.px !== 10'd0 || if_sm.py !== 10'd0) begin n_fail++; $display("FAIL wrap: got px=%0d py=%0d exp 0 0", if_sm.px, if_sm.py); end
      end
    end
    n_chk++; if (nfs != 2) begin n_fail++; $display("FAIL fs_count: got %0d exp 2", nfs); end
    n_chk++; if (fs1 != 750) begin n_fail++; $display("FAIL fs_first: got %0d exp 750", fs1); end
    n_chk++; if (fs2 - fs1 != 750) begin n_fail++; $display("FAIL fs_period: got %0d exp 750", fs2 - fs1); end
    n_chk++; if (pymax != 14) begin n_fail++; $display("FAIL py_max: got %0d exp 14", pymax); end
    n_chk++; if (vf1 != 502) begin n_fail++; $display("FAIL vs_fall: got %0d exp 502", vf1); end
    n_chk++; if (vr1 - vf1 != 100) begin n_fail++; $display("FAIL vs_width: got %0d exp 100", vr1 - vf1); end
    n_chk++; if (act_clks != 256) begin n_fail++; $display("FAIL active_clks: got %0d exp 256", act_clks); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL blanking: got %0d bad clks exp 0", bad); end
  endtask

  task automatic test_latency;
    int cnt, rs, rl, hsf_s, hsf_l, k, bad;
    logic vs_prev_s, vl_prev, hp_s, hp_l;
    logic [2:0] expv;
    do_reset();
    rs = -1; rl = -1; hsf_s = -1; hsf_l = -1; bad = 0;
    vs_prev_s = 1'b0; vl_prev = 1'b0; hp_s = 1'b1; hp_l = 1'b1;
    for (cnt = 1; cnt <= 200; cnt++) begin
      @(negedge clk);
      if (!vs_prev_s && vo_sm && rs < 0) rs = cnt;
      if (!vl_prev && vo_lat && rl < 0) rl = cnt;
      if (hp_s && !hs_sm && hsf_s < 0) hsf_s = cnt;
      if (hp_l && !hs_lat && hsf_l < 0) hsf_l = cnt;
      vs_prev_s = vo_sm; vl_prev = vo_lat; hp_s = hs_sm; hp_l = hs_lat;
      if (rl >= 0) begin
        k = cnt - rl;
        if (k % 2 == 0 && k / 2 < 16) begin
          expv = 3'((k / 2) % 8);
          if (rgb_lat !== expv || vo_lat !== 1'b1) bad++;
        end
        if (k == 32) begin
          n_chk++; if (vo_lat !== 1'b0 || rgb_lat !== 3'b000) begin n_fail++; $display("FAIL lat_line_end: got vo=%b rgb=%b exp 0 000", vo_lat, rgb_lat); end
        end
      end
    end
    n_chk++; if (rs != 2) begin n_fail++; $display("FAIL lat0_vo_rise: got %0d exp 2", rs); end
    n_chk++; if (rl != 6) begin n_fail++; $display("FAIL lat2_vo_rise: got %0d exp 6", rl); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL lat2_rgb_seq: got %0d bad pixels exp 0", bad); end
    n_chk++; if (hsf_s != 38) begin n_fail++; $display("FAIL lat0_hs_fall: got %0d exp 38", hsf_s); end
    n_chk++; if (hsf_l - hsf_s != 4) begin n_fail++; $display("FAIL lat2_hs_shift: got %0d exp 4", hsf_l - hsf_s); end
  endtask

  task automatic test_midframe_reset;
    int cnt, fs1, rs, rl;
    logic ps, pl;
    col_sm = 3'b101;
    do_reset();
    cnt = 0;
    while (cnt < 2000 && !(if_sm.px == 10'd10 && if_sm.py == 10'd5)) begin
      @(negedge clk);
      cnt++;
    end
    n_chk++; if (cnt >= 2000) begin n_fail++; $display("FAIL reach_mid: got timeout exp px=10 py=5"); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (if_sm.px !== 10'd0 || if_sm.py !== 10'd0 || rgb_sm !== 3'b000 || hs_sm !== 1'b1) begin n_fail++; $display("FAIL mid_clear: got px=%0d py=%0d rgb=%b hs=%b exp 0 0 000 1", if_sm.px, if_sm.py, rgb_sm, hs_sm); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fs1 = -1; rs = -1; rl = -1; ps = 1'b0; pl = 1'b0;
    for (cnt = 1; cnt <= 760; cnt++) begin
      @(negedge clk);
      if (if_sm.frame_start === 1'b1 && fs1 < 0) fs1 = cnt;
      if (!ps && vo_sm && rs < 0) rs = cnt;
      if (!pl && vo_lat && rl < 0) rl = cnt;
      ps = vo_sm; pl = vo_lat;
      if (cnt == 1) begin
        n_chk++; if (rgb_sm !== 3'b000) begin n_fail++; $display("FAIL mid_rgb_blank: got %b exp 000", rgb_sm); end
      end
      if (cnt == 2) begin
        n_chk++; if (rgb_sm !== 3'b101) begin n_fail++; $display("FAIL mid_rgb_first: got %b exp 101", rgb_sm); end
      end
    end
    n_chk++; if (fs1 != 750) begin n_fail++; $display("FAIL mid_fs: got %0d exp 750", fs1); end
    n_chk++; if (rs != 2) begin n_fail++; $display("FAIL mid_lat0_rise: got %0d exp 2", rs); end
    n_chk++; if (rl != 6) begin n_fail++; $display("FAIL mid_lat2_rise: got %0d exp 6", rl); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    col_def = 3'b000;
    col_sm  = 3'b000;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_latency();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
